// File: rtl/rvfi_mon_pkg.sv
// Shared types and combinational helpers for the RVFI retirement monitor.
// State encodings, saturating add, and lane popcount / prefix checks.
package rvfi_mon_pkg;

    localparam int ORDER_W  = 64;
    localparam int LANE_MAX = 32;

    typedef logic [1:0] state_t;

    localparam state_t HOLD    = 2'd0;
    localparam state_t RUN     = 2'd1;
    localparam state_t DONE    = 2'd2;
    localparam state_t STALLED = 2'd3;

    // Adds without wrapping: anything above max_val is pinned to max_val.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [63:0] max_val);
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            sat_add = max_val;
        end else begin
            sat_add = sum[63:0];
        end
    endfunction

    function automatic logic [5:0] popcount(input logic [LANE_MAX-1:0] v);
        popcount = '0;
        for (int i = 0; i < LANE_MAX; i++) begin
            popcount = popcount + {5'd0, v[i]};
        end
    endfunction

    // True when the set bits form a contiguous run starting at bit 0 (or none).
    function automatic logic is_prefix(input logic [LANE_MAX-1:0] v);
        is_prefix = ((v + 32'd1) & v) == 32'd0;
    endfunction

endpackage

// File: rtl/rvfi_sat_counter.sv
// Saturating up-counter; exposes the next value so callers can act on
// the post-update count in the same cycle.
module rvfi_sat_counter
    import rvfi_mon_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int INC_W = 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [INC_W-1:0] inc,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next
);

    localparam logic [63:0] MAX_VAL = (64'd1 << WIDTH) - 64'd1;

    always_comb begin
        count_next = WIDTH'(sat_add(64'(count), 64'(inc), MAX_VAL));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/rvfi_retire_monitor.sv
// RVFI retirement monitor: sequences core reset, counts retirements, checks order
// continuity, flags stalls. Define RVFI_RETIRE_MONITOR_FORMAL_EN for cover/assert statements.
module rvfi_retire_monitor
    import rvfi_mon_pkg::*;
#(
    parameter int NRET        = 1,
    parameter int RESET_DEPTH = 10,
    parameter int CNT_W       = 8,
    parameter int NTARGET     = 4,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                    clock,
    input  logic                    resetn,
    output logic                    dut_reset,
    input  logic [NRET-1:0]         rvfi_valid,
    input  logic [NRET*ORDER_W-1:0] rvfi_order,
    input  logic [NRET-1:0]         rvfi_trap,
    output logic [CNT_W-1:0]        insn_count,
    output logic [CNT_W-1:0]        cycle_count,
    output logic [CNT_W-1:0]        trap_count,
    output logic [NTARGET-1:0]      cov_hit,
    output logic                    order_err,
    output logic                    stall,
    output logic                    done,
    output state_t                  fsm_state
);

    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    state_t               state;
    state_t               state_next;
    logic                 active;
    logic [5:0]           n_ret;
    logic [5:0]           n_trap;
    logic [CNT_W-1:0]     insn_next;
    logic [CNT_W-1:0]     cycle_next;
    logic [CNT_W-1:0]     trap_next;
    logic [ORDER_W-1:0]   exp_order;
    logic                 lane_err;
    logic [WDOG_W-1:0]    wdog;
    logic [WDOG_W-1:0]    wdog_next;
    logic                 wdog_expire;
    logic [NTARGET-1:0]   cov_next;

    // Retirement strobes are meaningless while the core is still held in reset.
    assign active = (state != HOLD);

    always_comb begin
        n_ret  = '0;
        n_trap = '0;
        if (active) begin
            n_ret  = popcount(LANE_MAX'(rvfi_valid));
            n_trap = popcount(LANE_MAX'(rvfi_valid & rvfi_trap));
        end
    end

    rvfi_sat_counter #(.WIDTH(CNT_W), .INC_W(1)) u_cycle_cnt (
        .clock      (clock),
        .resetn     (resetn),
        .inc        (1'b1),
        .count      (cycle_count),
        .count_next (cycle_next)
    );

    rvfi_sat_counter #(.WIDTH(CNT_W), .INC_W(6)) u_insn_cnt (
        .clock      (clock),
        .resetn     (resetn),
        .inc        (n_ret),
        .count      (insn_count),
        .count_next (insn_next)
    );

    rvfi_sat_counter #(.WIDTH(CNT_W), .INC_W(6)) u_trap_cnt (
        .clock      (clock),
        .resetn     (resetn),
        .inc        (n_trap),
        .count      (trap_count),
        .count_next (trap_next)
    );

    always_comb begin
        lane_err = 1'b0;
        if (active) begin
            if (!is_prefix(LANE_MAX'(rvfi_valid))) begin
                lane_err = 1'b1;
            end
            for (int i = 0; i < NRET; i++) begin
                if (rvfi_valid[i] &&
                    (rvfi_order[ORDER_W*i +: ORDER_W] != exp_order + ORDER_W'(i))) begin
                    lane_err = 1'b1;
                end
            end
        end
    end

    // Watchdog only runs in RUN; DONE and STALLED freeze it.
    always_comb begin
        wdog_next   = wdog;
        wdog_expire = 1'b0;
        if (state == HOLD || n_ret != 6'd0) begin
            wdog_next = '0;
        end else if (state == RUN) begin
            wdog_next   = wdog + WDOG_W'(1);
            wdog_expire = (32'(wdog_next) >= WDOG_CYCLES);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HOLD: begin
                if (cycle_count == CNT_W'(RESET_DEPTH)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (wdog_expire) begin
                    state_next = STALLED;
                end else if (32'(insn_next) >= NTARGET) begin
                    state_next = DONE;
                end
            end
            default: state_next = state;
        endcase
    end

    always_comb begin
        cov_next = cov_hit;
        for (int k = 0; k < NTARGET; k++) begin
            if (32'(insn_next) >= k + 1) begin
                cov_next[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= HOLD;
            dut_reset <= 1'b1;
            exp_order <= '0;
            order_err <= 1'b0;
            stall     <= 1'b0;
            cov_hit   <= '0;
            wdog      <= '0;
        end else begin
            state     <= state_next;
            dut_reset <= (state_next == HOLD);
            exp_order <= exp_order + ORDER_W'(n_ret);
            order_err <= order_err | lane_err;
            stall     <= stall | wdog_expire;
            cov_hit   <= cov_next;
            wdog      <= wdog_next;
        end
    end

    assign done      = (32'(insn_count) >= NTARGET);
    assign fsm_state = state;

`ifdef RVFI_RETIRE_MONITOR_FORMAL_EN
    always @(posedge clock) begin
        if (resetn) begin
            for (int k = 0; k < NTARGET; k++) begin
                cover (cov_hit[k]);
            end
            cover (done);
            assert (!order_err);
            assert (!stall);
        end
    end
`endif

endmodule

// File: tb/tb_rvfi_retire_monitor.sv
// Directed bench for rvfi_retire_monitor: a vector table for the retire path plus
// hand-written sequences for reset timing, saturation, async reset and watchdog.
module tb_rvfi_retire_monitor;

    localparam int NRET        = 2;
    localparam int RESET_DEPTH = 10;
    localparam int CNT_W       = 4;
    localparam int NTARGET     = 4;
    localparam int WDOG_CYCLES = 8;

    localparam logic [1:0] S_HOLD    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] S_STALLED = 2'd3;

    logic                 clock;
    logic                 resetn;
    logic                 dut_reset;
    logic [NRET-1:0]      rvfi_valid;
    logic [NRET*64-1:0]   rvfi_order;
    logic [NRET-1:0]      rvfi_trap;
    logic [CNT_W-1:0]     insn_count;
    logic [CNT_W-1:0]     cycle_count;
    logic [CNT_W-1:0]     trap_count;
    logic [NTARGET-1:0]   cov_hit;
    logic                 order_err;
    logic                 stall;
    logic                 done;
    logic [1:0]           fsm_state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]  valid;
        logic [63:0] ord0;
        logic [63:0] ord1;
        logic [1:0]  trap;
        logic [3:0]  e_insn;
        logic [3:0]  e_trap;
        logic        e_err;
        logic [3:0]  e_cov;
        logic        e_done;
    } vec_t;

    vec_t vecs[7];

    rvfi_retire_monitor #(
        .NRET        (NRET),
        .RESET_DEPTH (RESET_DEPTH),
        .CNT_W       (CNT_W),
        .NTARGET     (NTARGET),
        .WDOG_CYCLES (WDOG_CYCLES)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .dut_reset   (dut_reset),
        .rvfi_valid  (rvfi_valid),
        .rvfi_order  (rvfi_order),
        .rvfi_trap   (rvfi_trap),
        .insn_count  (insn_count),
        .cycle_count (cycle_count),
        .trap_count  (trap_count),
        .cov_hit     (cov_hit),
        .order_err   (order_err),
        .stall       (stall),
        .done        (done),
        .fsm_state   (fsm_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] valid, input logic [63:0] o0,
                         input logic [63:0] o1, input logic [1:0] trap);
        rvfi_valid = valid;
        rvfi_order = {o1, o0};
        rvfi_trap  = trap;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_insn"},   64'(insn_count),  64'd0);
        check({tag, "_cycle"},  64'(cycle_count), 64'd0);
        check({tag, "_trap"},   64'(trap_count),  64'd0);
        check({tag, "_cov"},    64'(cov_hit),     64'd0);
        check({tag, "_err"},    64'(order_err),   64'd0);
        check({tag, "_stall"},  64'(stall),       64'd0);
        check({tag, "_done"},   64'(done),        64'd0);
        check({tag, "_dutrst"}, 64'(dut_reset),   64'd1);
        check({tag, "_state"},  64'(fsm_state),   64'(S_HOLD));
    endtask

    // Pulses resetn and waits (bounded) for dut_reset to fall; returns edges it stayed high.
    task automatic boot(output int high_cycles);
        drive(2'b00, 64'd0, 64'd0, 2'b00);
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        high_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            high_cycles++;
            if (!dut_reset) break;
        end
    endtask

    initial begin
        int hc;

        vecs[0] = '{2'b01, 64'd0, 64'd0, 2'b00, 4'd1, 4'd0, 1'b0, 4'b0001, 1'b0};
        vecs[1] = '{2'b11, 64'd1, 64'd2, 2'b10, 4'd3, 4'd1, 1'b0, 4'b0111, 1'b0};
        vecs[2] = '{2'b00, 64'd0, 64'd0, 2'b00, 4'd3, 4'd1, 1'b0, 4'b0111, 1'b0};
        vecs[3] = '{2'b01, 64'd3, 64'd0, 2'b01, 4'd4, 4'd2, 1'b0, 4'b1111, 1'b1};
        vecs[4] = '{2'b11, 64'd4, 64'd5, 2'b00, 4'd6, 4'd2, 1'b0, 4'b1111, 1'b1};
        vecs[5] = '{2'b10, 64'd0, 64'd7, 2'b00, 4'd7, 4'd2, 1'b1, 4'b1111, 1'b1};
        vecs[6] = '{2'b01, 64'd7, 64'd0, 2'b01, 4'd8, 4'd3, 1'b1, 4'b1111, 1'b1};

        resetn = 1'b0;
        drive(2'b00, 64'd0, 64'd0, 2'b00);
        repeat (2) @(posedge clock);
        #1;
        check_cleared("reset");

        // Reset sequencing: dut_reset high RESET_DEPTH+1 cycles.
        boot(hc);
        check("boot_high_cycles", 64'(hc), 64'd11);
        check("boot_dutrst", 64'(dut_reset), 64'd0);
        check("boot_cycle", 64'(cycle_count), 64'd11);
        check("boot_state", 64'(fsm_state), 64'(S_RUN));
        check("boot_insn", 64'(insn_count), 64'd0);

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].valid, vecs[i].ord0, vecs[i].ord1, vecs[i].trap);
            step();
            check($sformatf("vec%0d_insn", i), 64'(insn_count), 64'(vecs[i].e_insn));
            check($sformatf("vec%0d_trap", i), 64'(trap_count), 64'(vecs[i].e_trap));
            check($sformatf("vec%0d_err", i),  64'(order_err),  64'(vecs[i].e_err));
            check($sformatf("vec%0d_cov", i),  64'(cov_hit),    64'(vecs[i].e_cov));
            check($sformatf("vec%0d_done", i), 64'(done),       64'(vecs[i].e_done));
        end
        drive(2'b00, 64'd0, 64'd0, 2'b00);

        // Idle in DONE must not trip the watchdog.
        repeat (12) step();
        check("done_idle_stall", 64'(stall), 64'd0);
        check("done_idle_state", 64'(fsm_state), 64'(S_DONE));

        // Order gap 0 -> 2 with trap on the second retirement.
        boot(hc);
        drive(2'b01, 64'd0, 64'd0, 2'b00);
        step();
        check("gap_first_err", 64'(order_err), 64'd0);
        drive(2'b01, 64'd2, 64'd0, 2'b01);
        step();
        check("gap_err", 64'(order_err), 64'd1);
        check("gap_trap", 64'(trap_count), 64'd1);
        check("gap_insn", 64'(insn_count), 64'd2);
        drive(2'b00, 64'd0, 64'd0, 2'b00);

        // Saturation at 15 with CNT_W=4, then async reset mid-run.
        boot(hc);
        for (int i = 0; i < 20; i++) begin
            drive(2'b01, 64'(i), 64'd0, 2'b00);
            step();
        end
        drive(2'b00, 64'd0, 64'd0, 2'b00);
        check("sat_insn", 64'(insn_count), 64'd15);
        check("sat_cycle", 64'(cycle_count), 64'd15);
        check("sat_err", 64'(order_err), 64'd0);
        check("sat_done", 64'(done), 64'd1);
        check("sat_state", 64'(fsm_state), 64'(S_DONE));
        #2;
        resetn = 1'b0;
        #1;
        check_cleared("async");
        step();
        check_cleared("async_held");

        // Watchdog: WDOG_CYCLES idle cycles in RUN.
        boot(hc);
        repeat (WDOG_CYCLES - 1) step();
        check("wdog_pre_stall", 64'(stall), 64'd0);
        check("wdog_pre_state", 64'(fsm_state), 64'(S_RUN));
        step();
        check("wdog_stall", 64'(stall), 64'd1);
        check("wdog_state", 64'(fsm_state), 64'(S_STALLED));
        drive(2'b01, 64'd0, 64'd0, 2'b00);
        step();
        drive(2'b00, 64'd0, 64'd0, 2'b00);
        check("stalled_insn", 64'(insn_count), 64'd1);
        check("stalled_stall", 64'(stall), 64'd1);
        check("stalled_state", 64'(fsm_state), 64'(S_STALLED));
        check("stalled_err", 64'(order_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
